// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the mips_cpu bus arbiter: FSM states, the
// registered bus command bundle, and helpers that build a command per port.
package mips_cpu_pkg;

  localparam int unsigned BUS_W       = 32;
  localparam logic [3:0]  BYTEEN_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    BUS_I,
    BUS_D,
    DONE
  } arb_state_t;

  typedef struct packed {
    logic [BUS_W-1:0] address;
    logic [BUS_W-1:0] writedata;
    logic [3:0]       byteenable;
    logic             read;
    logic             write;
  } bus_cmd_t;

  // Instruction fetch is always a full-word read.
  function automatic bus_cmd_t fetch_cmd(input logic [BUS_W-1:0] addr);
    bus_cmd_t c;
    c.address    = addr;
    c.writedata  = '0;
    c.byteenable = BYTEEN_WORD;
    c.read       = 1'b1;
    c.write      = 1'b0;
    return c;
  endfunction

  function automatic bus_cmd_t data_cmd(input logic             wr,
                                        input logic [BUS_W-1:0] addr,
                                        input logic [BUS_W-1:0] wdata,
                                        input logic [3:0]       be);
    bus_cmd_t c;
    c.address    = addr;
    c.writedata  = wdata;
    c.byteenable = be;
    c.read       = !wr;
    c.write      = wr;
    return c;
  endfunction

endpackage

// File: rtl/mips_cpu_bus_arbiter_wait_counter.sv
// Saturating 8-bit stall counter. tc fires on the stall cycle that brings the
// count up to MAX_WAIT, so the owner can abort on that same edge.
module mips_cpu_bus_arbiter_wait_counter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(MAX_WAIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (inc && count != 8'hFF)
      count <= count + 8'd1;
  end

  assign tc = inc && (count >= TC_VAL);

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter for the single Avalon-style bus.
// One transfer in flight; command held through stalls; done pulses from DONE.
module mips_cpu_bus_arbiter
  import mips_cpu_pkg::*;
#(
  parameter bit          DATA_FIRST = 1'b1,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [BUS_W-1:0] i_address,
  output logic             i_done,
  output logic [BUS_W-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_write,
  input  logic [BUS_W-1:0] d_address,
  input  logic [BUS_W-1:0] d_writedata,
  input  logic [3:0]       d_byteenable,
  output logic             d_done,
  output logic [BUS_W-1:0] d_rdata,
  output logic             bus_error,
  output logic [BUS_W-1:0] address,
  output logic             write,
  output logic             read,
  input  logic             waitrequest,
  output logic [BUS_W-1:0] writedata,
  output logic [3:0]       byteenable,
  input  logic [BUS_W-1:0] readdata
);

  arb_state_t state;
  bus_cmd_t   cmd;
  logic       owner_d;
  logic       timed_out;
  logic       in_bus;
  logic       wait_tc;

  assign in_bus = (state == BUS_I) || (state == BUS_D);

  mips_cpu_bus_arbiter_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk   (clk),
    .reset (reset),
    .clear (!in_bus),
    .inc   (in_bus && waitrequest),
    .tc    (wait_tc)
  );

  assign address    = cmd.address;
  assign writedata  = cmd.writedata;
  assign byteenable = cmd.byteenable;
  assign read       = cmd.read;
  assign write      = cmd.write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= '0;
      owner_d   <= 1'b0;
      timed_out <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      bus_error <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          timed_out <= 1'b0;
          if (d_req && (DATA_FIRST || !i_req)) begin
            cmd     <= data_cmd(d_write, d_address, d_writedata, d_byteenable);
            owner_d <= 1'b1;
            state   <= BUS_D;
          end else if (i_req) begin
            cmd     <= fetch_cmd(i_address);
            owner_d <= 1'b0;
            state   <= BUS_I;
          end
        end
        BUS_I, BUS_D: begin
          if (!waitrequest) begin
            if (cmd.read) begin
              if (state == BUS_D) d_rdata <= readdata;
              else                i_rdata <= readdata;
            end
            cmd.read  <= 1'b0;
            cmd.write <= 1'b0;
            state     <= DONE;
          end else if (wait_tc) begin
            // Slave never answered: release the bus, report through DONE.
            cmd.read  <= 1'b0;
            cmd.write <= 1'b0;
            timed_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          i_done    <= !owner_d;
          d_done    <= owner_d;
          bus_error <= timed_out;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed bench for mips_cpu_bus_arbiter: two instances (D-first / I-first),
// both with a short stall timeout, fed by a tiny word-addressed memory model.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, i_req1, d_req1;
  logic [31:0] i_address, d_address, d_writedata;
  logic        d_write;
  logic [3:0]  d_byteenable;
  logic        waitrequest;

  logic        i_done0, d_done0, bus_error0, read0, write0;
  logic [31:0] i_rdata0, d_rdata0, address0, writedata0, readdata0;
  logic [3:0]  byteenable0;
  logic        i_done1, d_done1, bus_error1, read1, write1;
  logic [31:0] i_rdata1, d_rdata1, address1, writedata1, readdata1;
  logic [3:0]  byteenable1;

  logic [31:0] fetch_word;
  logic [31:0] mem1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_idone0 = 0, n_ddone0 = 0, n_idone1 = 0, n_ddone1 = 0, n_err0 = 0;
  logic idone_q0 = 1'b0, ddone_q0 = 1'b0;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter #(.DATA_FIRST(1'b1), .MAX_WAIT(4)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_address(i_address), .i_done(i_done0), .i_rdata(i_rdata0),
    .d_req(d_req), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_done(d_done0), .d_rdata(d_rdata0), .bus_error(bus_error0),
    .address(address0), .write(write0), .read(read0), .waitrequest(waitrequest),
    .writedata(writedata0), .byteenable(byteenable0), .readdata(readdata0)
  );

  mips_cpu_bus_arbiter #(.DATA_FIRST(1'b0), .MAX_WAIT(4)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req1), .i_address(i_address), .i_done(i_done1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_done(d_done1), .d_rdata(d_rdata1), .bus_error(bus_error1),
    .address(address1), .write(write1), .read(read1), .waitrequest(waitrequest),
    .writedata(writedata1), .byteenable(byteenable1), .readdata(readdata1)
  );

  // Word 1 (address 4) is real RAM; every other address returns fetch_word.
  assign readdata0 = (address0[5:2] == 4'd1) ? mem1 : fetch_word;
  assign readdata1 = (address1[5:2] == 4'd1) ? mem1 : fetch_word;

  always @(posedge clk) begin
    if (reset)
      mem1 <= 32'h11223344;
    else if (write0 && !waitrequest && address0[5:2] == 4'd1)
      for (int b = 0; b < 4; b++)
        if (byteenable0[b]) mem1[8*b +: 8] <= writedata0[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus invariants and done-pulse accounting, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rw_excl0", 32'(read0 & write0), 32'd0);
      chk("rw_excl1", 32'(read1 & write1), 32'd0);
      chk("i_done_width0", 32'(i_done0 & idone_q0), 32'd0);
      chk("d_done_width0", 32'(d_done0 & ddone_q0), 32'd0);
      if (i_done0)    n_idone0 <= n_idone0 + 1;
      if (d_done0)    n_ddone0 <= n_ddone0 + 1;
      if (i_done1)    n_idone1 <= n_idone1 + 1;
      if (d_done1)    n_ddone1 <= n_ddone1 + 1;
      if (bus_error0) n_err0   <= n_err0 + 1;
    end
    idone_q0 <= i_done0;
    ddone_q0 <= d_done0;
  end

  initial begin
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; i_req1 = 1'b0; d_req1 = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0; d_write = 1'b0;
    d_byteenable = '0; waitrequest = 1'b0;
    fetch_word = 32'h8C030001;
    tick(); tick();
    chk("rst_read",   32'(read0), 32'd0);
    chk("rst_write",  32'(write0), 32'd0);
    chk("rst_addr",   address0, 32'd0);
    chk("rst_wdata",  writedata0, 32'd0);
    chk("rst_be",     32'(byteenable0), 32'd0);
    chk("rst_idone",  32'(i_done0), 32'd0);
    chk("rst_ddone",  32'(d_done0), 32'd0);
    chk("rst_err",    32'(bus_error0), 32'd0);
    chk("rst_irdata", i_rdata0, 32'd0);
    chk("rst_drdata", d_rdata0, 32'd0);
    chk("rst_read1",  32'(read1), 32'd0);
    reset = 1'b0;

    // Fetch, zero wait states.
    i_req = 1'b1; i_address = 32'hBFC00000;
    tick();
    chk("f_read",  32'(read0), 32'd1);
    chk("f_addr",  address0, 32'hBFC00000);
    chk("f_be",    32'(byteenable0), 32'hF);
    chk("f_write", 32'(write0), 32'd0);
    tick();
    chk("f_read_drop", 32'(read0), 32'd0);
    chk("f_done_early", 32'(i_done0), 32'd0);
    tick();
    chk("f_done",  32'(i_done0), 32'd1);
    chk("f_rdata", i_rdata0, 32'h8C030001);
    i_req = 1'b0;
    tick();
    chk("f_done_off", 32'(i_done0), 32'd0);
    chk("f_idle",     32'(read0), 32'd0);

    // Store with two wait states.
    d_req = 1'b1; d_write = 1'b1; d_address = 32'h4;
    d_writedata = 32'hDEADBEEF; d_byteenable = 4'b0011; waitrequest = 1'b1;
    tick();
    chk("s_write", 32'(write0), 32'd1);
    chk("s_read",  32'(read0), 32'd0);
    chk("s_addr",  address0, 32'h4);
    chk("s_wdata", writedata0, 32'hDEADBEEF);
    chk("s_be",    32'(byteenable0), 32'h3);
    tick();
    chk("s_hold1_write", 32'(write0), 32'd1);
    chk("s_hold1_wdata", writedata0, 32'hDEADBEEF);
    tick();
    chk("s_hold2_write", 32'(write0), 32'd1);
    chk("s_hold2_addr",  address0, 32'h4);
    waitrequest = 1'b0;
    tick();
    chk("s_write_drop", 32'(write0), 32'd0);
    chk("s_done_early", 32'(d_done0), 32'd0);
    tick();
    chk("s_done", 32'(d_done0), 32'd1);
    chk("s_ram",  mem1, 32'h1122BEEF);
    d_req = 1'b0; d_write = 1'b0;
    tick();
    chk("s_done_off", 32'(d_done0), 32'd0);

    // Simultaneous load + fetch on both priority settings.
    d_req = 1'b1; i_req = 1'b1; d_req1 = 1'b1; i_req1 = 1'b1;
    d_address = 32'h4; i_address = 32'hBFC00000;
    tick();
    chk("p0_first_addr", address0, 32'h4);
    chk("p0_first_read", 32'(read0), 32'd1);
    chk("p1_first_addr", address1, 32'hBFC00000);
    chk("p1_first_read", 32'(read1), 32'd1);
    tick();
    tick();
    chk("p0_ddone",  32'(d_done0), 32'd1);
    chk("p0_drdata", d_rdata0, 32'h1122BEEF);
    chk("p0_idone_wait", 32'(i_done0), 32'd0);
    chk("p1_idone",  32'(i_done1), 32'd1);
    chk("p1_irdata", i_rdata1, 32'h8C030001);
    d_req = 1'b0; i_req1 = 1'b0;
    tick();
    chk("p0_second_addr", address0, 32'hBFC00000);
    chk("p0_second_read", 32'(read0), 32'd1);
    chk("p1_second_addr", address1, 32'h4);
    chk("p1_second_read", 32'(read1), 32'd1);
    tick();
    tick();
    chk("p0_idone",  32'(i_done0), 32'd1);
    chk("p0_irdata", i_rdata0, 32'h8C030001);
    chk("p1_ddone",  32'(d_done1), 32'd1);
    chk("p1_drdata", d_rdata1, 32'h1122BEEF);
    i_req = 1'b0; d_req1 = 1'b0;
    tick();
    chk("p_idle0", 32'(read0), 32'd0);
    chk("p_idle1", 32'(read1), 32'd0);

    // Timeout: waitrequest stuck, MAX_WAIT=4.
    fetch_word = 32'h12345678;
    i_req = 1'b1; waitrequest = 1'b1;
    tick();
    chk("t_read", 32'(read0), 32'd1);
    tick(); tick(); tick();
    chk("t_read_hold", 32'(read0), 32'd1);
    chk("t_err_early", 32'(bus_error0), 32'd0);
    tick();
    chk("t_read_drop", 32'(read0), 32'd0);
    chk("t_done_early", 32'(i_done0), 32'd0);
    tick();
    chk("t_done",  32'(i_done0), 32'd1);
    chk("t_err",   32'(bus_error0), 32'd1);
    chk("t_rdata", i_rdata0, 32'h8C030001);
    i_req = 1'b0; waitrequest = 1'b0;
    tick();
    chk("t_err_off",  32'(bus_error0), 32'd0);
    chk("t_done_off", 32'(i_done0), 32'd0);

    // Reset in the middle of a stalled fetch, then retry.
    i_req = 1'b1; waitrequest = 1'b1;
    tick();
    chk("r_read", 32'(read0), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("r_read_rst", 32'(read0), 32'd0);
    chk("r_done_rst", 32'(i_done0), 32'd0);
    reset = 1'b0; waitrequest = 1'b0;
    tick();
    chk("r_retry_read", 32'(read0), 32'd1);
    chk("r_retry_addr", address0, 32'hBFC00000);
    tick();
    chk("r_retry_drop", 32'(read0), 32'd0);
    tick();
    chk("r_retry_done",  32'(i_done0), 32'd1);
    chk("r_retry_rdata", i_rdata0, 32'h12345678);
    i_req = 1'b0;
    tick();
    chk("r_done_off", 32'(i_done0), 32'd0);

    chk("cnt_idone0", 32'(n_idone0), 32'd4);
    chk("cnt_ddone0", 32'(n_ddone0), 32'd2);
    chk("cnt_idone1", 32'(n_idone1), 32'd1);
    chk("cnt_ddone1", 32'(n_ddone1), 32'd1);
    chk("cnt_err0",   32'(n_err0),   32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
Name: mips_cpu_bus_arbiter

Overview:
- Shares the single Avalon-style memory bus of mips_cpu_bus between two requesters: instruction fetch (I-port) and load/store unit (D-port).
- Grants the bus to one requester at a time, holds the bus command stable through waitrequest stalls, and registers readdata.
- Returns a one-cycle done pulse to the granted requester.
- Sits between the CPU control FSM and the bus pins `address`/`read`/`write`/`writedata`/`byteenable`/`readdata`/`waitrequest`.

Parameters:
- DATA_FIRST, 1, when 1 the D-port wins simultaneous requests; when 0 the I-port wins.
- MAX_WAIT, 255, number of consecutive waitrequest cycles after which the transfer is aborted and the error pulse is raised.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- i_req  input  1  fetch request; held high with i_address until i_done
- i_address  input  32  fetch address (word aligned)
- i_done  output  1  one-cycle pulse: i_rdata valid
- i_rdata  output  32  fetched word
- d_req  input  1  data request; held with its fields until d_done
- d_write  input  1  1=store, 0=load
- d_address  input  32  data address (word aligned)
- d_writedata  input  32  store data
- d_byteenable  input  4  byte lanes
- d_done  output  1  one-cycle pulse: transfer complete; d_rdata valid for loads
- d_rdata  output  32  loaded word
- bus_error  output  1  one-cycle pulse on MAX_WAIT timeout
- address  output  32  bus address
- write  output  1  bus write strobe
- read  output  1  bus read strobe
- waitrequest  input  1  slave stall
- writedata  output  32  bus write data
- byteenable  output  4  bus byte enables
- readdata  input  32  bus read data

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: read=0, write=0, address=0, writedata=0, byteenable=0, i_done=0, d_done=0, bus_error=0, i_rdata=0, d_rdata=0, wait counter=0, state=IDLE.
- FSM states: IDLE, BUS_I, BUS_D, DONE.
- IDLE:
  - Sample the requests. If both are high, the winner is set by DATA_FIRST; otherwise the single requester wins.
  - Register the winner's fields onto the bus outputs and go to BUS_I or BUS_D.
  - I-port transfers: read=1, write=0, byteenable=4'b1111.
  - D-port transfers: read=!d_write, write=d_write.
- BUS_x:
  - All bus outputs are held constant while waitrequest=1, and the wait counter increments.
  - On the first edge with waitrequest=0: capture readdata into x_rdata (reads only), drop read/write to 0, go to DONE.
- DONE: pulse x_done=1 for exactly one cycle, then return to IDLE. The bus is idle (read=write=0) in DONE.
- Latency with zero wait states:
  - Request high at edge N (IDLE) -> bus strobe visible after edge N.
  - Transfer completes at edge N+1 -> x_done high after edge N+2.
  - Minimum 3 cycles per transfer. Each waitrequest cycle adds one.
- Back-to-back: a requester must drop req in the cycle its done is seen, otherwise the request is re-served. The arbiter does not filter.
- No preemption: once a transfer is granted, the other port waits regardless of priority.
- Timeout: when the wait counter reaches MAX_WAIT in BUS_x:
  - Drop read/write.
  - Pulse bus_error and x_done together; x_rdata is unchanged.
  - Return to IDLE via DONE.
- Never read=1 and write=1 simultaneously. address[1:0] is forwarded unchanged; alignment checking is the CPU's job.
- Reset mid-transfer: strobes return to 0 at the reset edge, and any pending done is discarded.
- Requests arriving in BUS_x or DONE are only evaluated in IDLE.

Decomposition:
- Shared package mips_cpu_pkg:
  - arb_state_t enum {IDLE, BUS_I, BUS_D, DONE}.
  - Constant BYTEEN_WORD=4'b1111.
  - Bus width constant 32.
- One natural sub-module: mips_cpu_bus_arbiter_wait_counter (8-bit saturating stall counter with clear and terminal-count output).

Test Plan:
- I-only fetch, zero wait: i_req=1, i_address=32'hBFC00000, RAM readdata=32'h8C030001 -> read=1 and address=BFC00000 one cycle after request; i_done pulse on the third edge with i_rdata=32'h8C030001.
- D store with 2 wait states: d_write=1, d_address=32'h00000004, d_writedata=32'hDEADBEEF, d_byteenable=4'b0011 -> write held 3 cycles with stable fields; d_done after 5 cycles; RAM word 1 lower half = BEEF.
- Simultaneous requests, DATA_FIRST=1: both requests high in IDLE -> D transfer first, I transfer starts in the IDLE after d_done. Repeat with DATA_FIRST=0 -> order reversed.
- Timeout: waitrequest stuck at 1, MAX_WAIT=4 -> read drops after 4 stall cycles; bus_error and i_done pulse together; i_rdata unchanged.
- Reset mid-read: assert reset during BUS_I with waitrequest=1 -> read=0 after that edge; no i_done; fetch of BFC00000 succeeds after reset.
- Invariant checks across all tests: read&write never 1; done pulses exactly one cycle per granted request.
